// File: rtl/neuron_pkg.sv
// Shared types and sign-magnitude helpers for the neuron processing element.
package neuron_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_ACT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ACT_IDENTITY = 2'd0,
    ACT_RELU     = 2'd1,
    ACT_RSVD2    = 2'd2,
    ACT_RSVD3    = 2'd3
  } act_mode_t;

  // Helpers work on a generous fixed width; callers size-cast in and out.
  localparam int unsigned MAX_W = 128;
  typedef logic [MAX_W-1:0] wide_t;

  // Sign-magnitude to two's complement; a zero magnitude maps to 0 for either sign.
  function automatic wide_t sm_to_tc(input logic sign, input wide_t mag);
    return sign ? (~mag + wide_t'(1)) : mag;
  endfunction

  // Absolute value of a two's-complement number.
  function automatic wide_t tc_abs(input wide_t val);
    return val[MAX_W-1] ? (~val + wide_t'(1)) : val;
  endfunction

  // Clamp a magnitude to a ceiling.
  function automatic wide_t sat_mag(input wide_t mag, input wide_t limit);
    return (mag > limit) ? limit : mag;
  endfunction

endpackage

// File: rtl/neuron_pe_sm_mult.sv
// Registered sign-magnitude multiplier: one-cycle latency, result tagged valid.
module sm_mult #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [DATA_W-1:0]         a,
  input  logic [DATA_W-1:0]         b,
  output logic                      valid,
  output logic                      sign,
  output logic [2*(DATA_W-1)-1:0]   mag
);

  localparam int unsigned MAG_W = 2 * (DATA_W - 1);

  // Product register: captures |a|*|b| and the xor of signs on each enabled cycle.
  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      sign  <= 1'b0;
      mag   <= '0;
    end else begin
      valid <= en;
      if (en) begin
        sign <= a[DATA_W-1] ^ b[DATA_W-1];
        mag  <= MAG_W'(a[DATA_W-2:0]) * MAG_W'(b[DATA_W-2:0]);
      end
    end
  end

endmodule

// File: rtl/neuron_pe.sv
// Sign-magnitude MAC neuron: bias + sum(x*w), activation, saturation, valid/ready result.
module neuron_pe
  import neuron_pkg::*;
#(
  parameter int unsigned N_INPUTS = 128,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FRAC_W   = 8,
  parameter int unsigned ACC_W    = 2 * DATA_W + $clog2(N_INPUTS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        act_mode,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(N_INPUTS + 1);
  localparam int unsigned MAG_W = 2 * (DATA_W - 1);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  act_mode_t         mode_q;
  logic              prod_valid, prod_sign;
  logic [MAG_W-1:0]  prod_mag;
  logic              accept_start, beat, last_beat;
  logic [ACC_W-1:0]  bias_acc, prod_acc;
  wide_t             acc_mag, res_mag;
  logic              res_neg;
  logic [DATA_W-1:0] act_result;

  assign accept_start = (state == S_IDLE) && start;
  assign beat         = in_valid && in_ready;
  assign last_beat    = beat && (cnt == CNT_W'(N_INPUTS - 1));
  assign busy         = (state != S_IDLE);
  assign out_valid    = (state == S_DONE);

  // Bias is pre-aligned to the product's 2*FRAC_W fractional bits.
  assign bias_acc = ACC_W'(sm_to_tc(bias[DATA_W-1], wide_t'(bias[DATA_W-2:0]))) << FRAC_W;
  assign prod_acc = ACC_W'(sm_to_tc(prod_sign, wide_t'(prod_mag)));

  sm_mult #(.DATA_W(DATA_W)) u_mult (
    .clk   (clk),
    .rst   (rst),
    .en    (beat),
    .a     (in_data),
    .b     (in_weight),
    .valid (prod_valid),
    .sign  (prod_sign),
    .mag   (prod_mag)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Next-state logic; start is only honoured from IDLE.
  // NOTE: next_state gets a default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start)     next_state = S_ACCUM;
      S_ACCUM: if (last_beat) next_state = S_DRAIN;
      S_DRAIN:                next_state = S_ACT;
      S_ACT:                  next_state = S_DONE;
      S_DONE:  if (out_ready) next_state = S_IDLE;
      default:                next_state = S_IDLE;
    endcase
  end

  // Job control: latch mode, count beats, own the registered in_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready <= 1'b0;
      cnt      <= '0;
      mode_q   <= ACT_IDENTITY;
    end else if (accept_start) begin
      in_ready <= 1'b1;
      cnt      <= '0;
      mode_q   <= act_mode_t'(act_mode);
    end else if (beat) begin
      cnt <= cnt + 1'b1;
      if (last_beat) in_ready <= 1'b0;
    end
  end

  // Accumulator: seeded with the bias at start, then adds each registered product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              acc <= '0;
    else if (accept_start) acc <= bias_acc;
    else if (prod_valid)   acc <= acc + prod_acc;
  end

  // Activation: truncate toward zero, saturate, suppress negative zero, apply ReLU.
  always_comb begin
    acc_mag = tc_abs(wide_t'(signed'(acc))) >> FRAC_W;
    res_mag = sat_mag(acc_mag, wide_t'({(DATA_W-1){1'b1}}));
    res_neg = acc[ACC_W-1] && (res_mag != '0);
    if (res_neg && (mode_q == ACT_RELU)) act_result = '0;
    else                                 act_result = {res_neg, (DATA_W-1)'(res_mag)};
  end

  // Result register: loaded in ACT, then held through DONE and the following IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                out <= '0;
    else if (state == S_ACT) out <= act_result;
  end

endmodule

// File: tb/tb_neuron_pe.sv
// Randomised and directed bench for neuron_pe against an arithmetic reference model.
module tb_neuron_pe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]  act_mode;
  logic [15:0] bias, in_data, in_weight, out;

  logic        u_start, u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_busy;
  logic [1:0]  u_act_mode;
  logic [15:0] u_bias, u_in_data, u_in_weight, u_out;

  neuron_pe #(.N_INPUTS(4), .DATA_W(16), .FRAC_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .act_mode(act_mode), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
  );

  neuron_pe #(.N_INPUTS(1), .DATA_W(16), .FRAC_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(u_start), .act_mode(u_act_mode), .bias(u_bias),
    .in_valid(u_in_valid), .in_ready(u_in_ready), .in_data(u_in_data), .in_weight(u_in_weight),
    .out_valid(u_out_valid), .out_ready(u_out_ready), .out(u_out), .busy(u_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic: values as signed integers scaled by 2^8.
  function automatic longint sm_val(input logic [15:0] v);
    longint m = longint'(v[14:0]);
    return v[15] ? -m : m;
  endfunction

  function automatic logic [15:0] model(input logic [15:0] b, input logic [1:0] mode,
                                        input logic [15:0] xs[4], input logic [15:0] ws[4],
                                        input int n);
    longint acc = sm_val(b) * 256;
    longint mag;
    logic   neg;
    for (int i = 0; i < n; i++) acc += sm_val(xs[i]) * sm_val(ws[i]);
    mag = (acc < 0) ? -acc : acc;
    mag = mag / 256;
    if (mag > 32767) mag = 32767;
    neg = (acc < 0) && (mag != 0);
    if (neg && mode == 2'd1) return 16'h0000;
    return {neg, mag[14:0]};
  endfunction

  function automatic logic [15:0] rand_op();
    case ($urandom_range(7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'($urandom) & 16'h80FF;
      4:       return 16'($urandom) & 16'h83FF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Compare process: every accepted result against the model, and stability while stalled.
  logic        prev_hold = 1'b0;
  logic [15:0] prev_out  = '0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_out", 32'(out), 32'(prev_out));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
        else                   check("result", 32'(out), 32'(exp_q.pop_front()));
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = out;
    end
  end

  task automatic run_job(input logic [15:0] b, input logic [1:0] mode,
                         input logic [15:0] xs[4], input logic [15:0] ws[4],
                         input int bubble_pct, input int hold, input bit spurious,
                         input bit chk_lat, output logic [15:0] got);
    int acc_n = 0;
    int budget = 200;
    int lat = 1;
    bit seen = 0;
    got = '0;
    exp_q.push_back(model(b, mode, xs, ws, 4));
    @(posedge clk); #1;
    start = 1'b1; bias = b; act_mode = mode;
    @(posedge clk); #1;
    start = 1'b0; bias = 16'($urandom); act_mode = 2'($urandom);
    while (acc_n < 4 && budget > 0) begin
      budget--;
      in_valid  = ($urandom_range(99) >= bubble_pct);
      in_data   = in_valid ? xs[acc_n] : 16'($urandom);
      in_weight = in_valid ? ws[acc_n] : 16'($urandom);
      if (spurious && acc_n == 1) start = 1'b1;
      @(negedge clk);
      if (budget == 199) begin
        check("busy_after_start", 32'(busy), 32'd1);
        check("ready_after_start", 32'(in_ready), 32'd1);
      end
      if (start) check("busy_spurious_accum", 32'(busy), 32'd1);
      if (in_valid && in_ready) acc_n++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
    if (acc_n < 4) begin
      check("beat_timeout", 32'(acc_n), 32'd4);
      return;
    end
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      else begin @(posedge clk); #1; lat++; end
    end
    if (!seen) begin
      check("out_valid_timeout", 32'd0, 32'd1);
      return;
    end
    if (chk_lat) check("latency", 32'(lat), 32'd3);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      start = spurious && (h == 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; start = spurious;
    @(negedge clk);
    got = out;
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle_after_done", 32'(busy), 32'd0);
    check("out_held_idle", 32'(out), 32'(got));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] xs[4], ws[4], xs1[4], ws1[4], got;
    int acc_n, budget;
    bit seen;
    rst = 1'b0; start = 1'b0; act_mode = '0; bias = '0; in_valid = 1'b0;
    in_data = '0; in_weight = '0; out_ready = 1'b0;
    u_start = 1'b0; u_act_mode = '0; u_bias = '0; u_in_valid = 1'b0;
    u_in_data = '0; u_in_weight = '0; u_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out", 32'(out), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Basic: 4 x (1.0 * 0.5) = 2.0
    xs = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    ws = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
    run_job(16'h0000, 2'd0, xs, ws, 0, 0, 0, 1, got);
    check("basic_lit", 32'(got), 32'h0200);

    // Negative weights with bias, identity then ReLU.
    ws = '{16'h8080, 16'h8080, 16'h8080, 16'h8080};
    run_job(16'h0040, 2'd0, xs, ws, 0, 0, 0, 1, got);
    check("sign_identity_lit", 32'(got), 32'h81C0);
    run_job(16'h0040, 2'd1, xs, ws, 0, 0, 0, 0, got);
    check("sign_relu_lit", 32'(got), 32'h0000);

    // Saturation both ways.
    xs = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    ws = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    run_job(16'h0000, 2'd0, xs, ws, 0, 0, 0, 0, got);
    check("sat_pos_lit", 32'(got), 32'h7FFF);
    ws = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    run_job(16'h0000, 2'd0, xs, ws, 0, 0, 0, 0, got);
    check("sat_neg_lit", 32'(got), 32'hFFFF);

    // Negative-zero operands contribute nothing: 2 x (1.0 * 0.5) = 1.0
    xs = '{16'h8000, 16'h0100, 16'h8000, 16'h0100};
    ws = '{16'h7FFF, 16'h0080, 16'h1234, 16'h0080};
    run_job(16'h8000, 2'd0, xs, ws, 0, 0, 0, 0, got);
    check("neg_zero_lit", 32'(got), 32'h0100);

    // Bubbles, output stall, and ignored start pulses on the basic job.
    xs = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    ws = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
    run_job(16'h0000, 2'd0, xs, ws, 50, 0, 0, 0, got);
    check("bubbles_lit", 32'(got), 32'h0200);
    run_job(16'h0000, 2'd0, xs, ws, 0, 5, 0, 0, got);
    check("stall_lit", 32'(got), 32'h0200);
    run_job(16'h0000, 2'd0, xs, ws, 0, 3, 1, 0, got);
    check("spurious_start_lit", 32'(got), 32'h0200);

    // Reset in the middle of accumulation.
    @(posedge clk); #1;
    start = 1'b1; bias = 16'h0100; act_mode = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    acc_n = 0; budget = 20;
    while (acc_n < 2 && budget > 0) begin
      budget--;
      in_valid = 1'b1; in_data = 16'h0100; in_weight = 16'h0080;
      @(negedge clk);
      if (in_valid && in_ready) acc_n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_job(16'h0000, 2'd0, xs, ws, 0, 0, 0, 1, got);
    check("after_reset_lit", 32'(got), 32'h0200);

    // Randomised jobs against the model.
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < 4; i++) begin
        xs[i] = rand_op();
        ws[i] = rand_op();
      end
      run_job(rand_op(), 2'($urandom), xs, ws, $urandom_range(60),
              $urandom_range(3), 1'($urandom), 0, got);
    end

    // Single-input instance: 3.0 * -2.0 + 1.0 = -5.0
    xs1 = '{16'h0300, 16'h0000, 16'h0000, 16'h0000};
    ws1 = '{16'h8200, 16'h0000, 16'h0000, 16'h0000};
    @(posedge clk); #1;
    u_start = 1'b1; u_bias = 16'h0100; u_act_mode = 2'd0;
    @(posedge clk); #1;
    u_start = 1'b0;
    u_in_valid = 1'b1; u_in_data = xs1[0]; u_in_weight = ws1[0];
    @(negedge clk);
    check("n1_in_ready", 32'(u_in_ready), 32'd1);
    @(posedge clk); #1;
    u_in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (u_out_valid) seen = 1;
      else begin @(posedge clk); #1; end
    end
    check("n1_out_valid", 32'(seen), 32'd1);
    check("n1_lit", 32'(u_out), 32'h8500);
    check("n1_model", 32'(u_out), 32'(model(16'h0100, 2'd0, xs1, ws1, 1)));
    @(posedge clk); #1;
    u_out_ready = 1'b1;
    @(posedge clk); #1;
    u_out_ready = 1'b0;
    @(negedge clk);
    check("n1_idle", 32'(u_busy), 32'd0);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) check("results_outstanding", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
